// File: rtl/cmd_frame_rx.sv
// Serial command receiver: deserialises start/addr/cmd/parity/stop frames and
// broadcasts each valid command as a one-cycle address/command strobe.
module cmd_frame_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [4:0]  IDLE_ADDR    = 5'd0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ser_i,
    output logic [4:0] address_o,
    output logic       command_o,
    output logic       strobe_o,
    output logic       err_o
);

    localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StWaitHigh, StIdle, StStart, StData, StParity, StStop
    } state_e;

    logic            sync1_q, s_q, s_prev_q;
    logic [1:0]      fill_q;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [5:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [4:0]      address_q, address_d;
    logic            command_q, command_d;
    logic            strobe_q, strobe_d;
    logic            err_q, err_d;
    logic            tick;

    // fill_q marks when the synchroniser holds real line samples rather than
    // its reset value, so a line held low through reset is never seen as high.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1_q  <= 1'b1;
            s_q      <= 1'b1;
            s_prev_q <= 1'b1;
            fill_q   <= 2'b00;
        end else begin
            sync1_q  <= ser_i;
            s_q      <= sync1_q;
            s_prev_q <= s_q;
            fill_q   <= {fill_q[0], 1'b1};
        end
    end

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        address_d = IDLE_ADDR;
        command_d = 1'b0;
        strobe_d  = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            StWaitHigh: begin
                if (fill_q[1] && s_q) state_d = StIdle;
            end
            StIdle: begin
                if (s_prev_q && !s_q) begin
                    state_d = StStart;
                    cnt_d   = HalfLoad;
                end
            end
            StStart: begin
                if (!tick) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (s_q) begin
                    state_d = StIdle;
                end else begin
                    state_d = StData;
                    cnt_d   = FullLoad;
                    bit_d   = 3'd0;
                end
            end
            StData: begin
                if (!tick) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    shift_d = {s_q, shift_q[5:1]};
                    cnt_d   = FullLoad;
                    if (bit_q == 3'd5) state_d = StParity;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            StParity: begin
                if (!tick) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    par_d   = s_q;
                    cnt_d   = FullLoad;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (!tick) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    if (s_q && !(^{shift_q, par_q})) begin
                        address_d = shift_q[4:0];
                        command_d = shift_q[5];
                        strobe_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = s_q ? StIdle : StWaitHigh;
                end
            end
            default: state_d = StWaitHigh;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= StWaitHigh;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 6'd0;
            par_q     <= 1'b0;
            address_q <= IDLE_ADDR;
            command_q <= 1'b0;
            strobe_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            address_q <= address_d;
            command_q <= command_d;
            strobe_q  <= strobe_d;
            err_q     <= err_d;
        end
    end

    assign address_o = address_q;
    assign command_o = command_q;
    assign strobe_o  = strobe_q;
    assign err_o     = err_q;

endmodule
